// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage: NOP encoding, default widths, PC reset and increment.
package if_id_stage_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          CTRL_W_DEF   = 9;
  localparam int          CNT_W_DEF    = 16;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// PC, IF/ID register and ID/EX control register with stall, bubble and branch-flush handling.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          CTRL_W   = CTRL_W_DEF,
  parameter int          CNT_W    = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              nop,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  input  logic [31:0]       Instr_In,
  input  logic [CTRL_W-1:0] ID_Ctrl_In,
  output logic [31:0]       PC,
  output logic [31:0]       IF_ID_Instr,
  output logic [31:0]       IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       pc_plus4;

  assign pc_plus4 = pc_q + PC_INC;

  // Branch flush takes priority over every stall control.
  always_comb begin
    pc_d = pc_q;
    if (Branch_Taken) begin
      pc_d = Branch_Target;
    end else if (PCWrite) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (Branch_Taken) begin
      instr_d   = NOP_INSTR;
      pcplus4_d = 32'h0;
      valid_d   = 1'b0;
    end else if (IF_ID_Write) begin
      instr_d   = Instr_In;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end
  end

  always_comb begin
    ctrl_d = ID_Ctrl_In;
    if (Branch_Taken || nop) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q      <= PC_RESET;
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // A bubble coinciding with a flush is counted only as a flush.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (nop && !Branch_Taken),
    .count (Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (Branch_Taken),
    .count (Flush_Count)
  );

  assign PC            = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pcplus4_q;
  assign IF_ID_Valid   = valid_q;
  assign ID_EX_Ctrl    = ctrl_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with PC_RESET = 0x40 and 4-bit counters.
module tb_if_id_stage;

  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              PCWrite, IF_ID_Write, nop, Branch_Taken;
  logic [31:0]       Branch_Target, Instr_In;
  logic [CTRL_W-1:0] ID_Ctrl_In;
  logic [31:0]       PC, IF_ID_Instr, IF_ID_PCPlus4;
  logic              IF_ID_Valid;
  logic [CTRL_W-1:0] ID_EX_Ctrl;
  logic [CNT_W-1:0]  Stall_Count, Flush_Count;

  int n_cmp = 0;
  int n_err = 0;

  if_id_stage #(
    .PC_RESET (32'h0000_0040),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .nop           (nop),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Instr_In      (Instr_In),
    .ID_Ctrl_In    (ID_Ctrl_In),
    .PC            (PC),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
    .IF_ID_Valid   (IF_ID_Valid),
    .ID_EX_Ctrl    (ID_EX_Ctrl),
    .Stall_Count   (Stall_Count),
    .Flush_Count   (Flush_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ctl(input logic pcw, input logic ifw, input logic bub,
                         input logic bt, input logic [31:0] tgt);
    PCWrite = pcw; IF_ID_Write = ifw; nop = bub; Branch_Taken = bt; Branch_Target = tgt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v);
    check({tag, "_pc"}, PC, pc);
    check({tag, "_instr"}, IF_ID_Instr, ins);
    check({tag, "_pcp4"}, IF_ID_PCPlus4, p4);
    check({tag, "_valid"}, {31'b0, IF_ID_Valid}, {31'b0, v});
    $display("step %s: PC=%h instr=%h pcp4=%h valid=%0d ctrl=%h stall=%0d flush=%0d",
             tag, PC, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl, Stall_Count, Flush_Count);
  endtask

  initial begin
    Rst = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    Instr_In = 32'h1111_0040;
    ID_Ctrl_In = 9'h1A5;
    #3;
    check_ifid("reset", 32'h40, 32'h0, 32'h0, 1'b0);
    check("reset_ctrl", {23'b0, ID_EX_Ctrl}, 32'h0);
    check("reset_stall", {28'b0, Stall_Count}, 32'h0);
    check("reset_flush", {28'b0, Flush_Count}, 32'h0);
    #9 Rst = 1'b0;

    // Free-running fetch from PC_RESET
    step();
    check_ifid("run1", 32'h44, 32'h1111_0040, 32'h44, 1'b1);
    check("run1_ctrl", {23'b0, ID_EX_Ctrl}, 32'h1A5);
    Instr_In = 32'h1111_0044; ID_Ctrl_In = 9'h0F0;
    step();
    check_ifid("run2", 32'h48, 32'h1111_0044, 32'h48, 1'b1);
    check("run2_ctrl", {23'b0, ID_EX_Ctrl}, 32'h0F0);
    Instr_In = 32'h1111_0048;
    step();
    check_ifid("run3", 32'h4C, 32'h1111_0048, 32'h4C, 1'b1);

    // Redirect to 0x0C, then fetch once to reach PC = 0x10
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_000C);
    step();
    check_ifid("br0c", 32'h0C, 32'h0, 32'h0, 1'b0);
    check("br0c_flush", {28'b0, Flush_Count}, 32'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    Instr_In = 32'h3333_000C; ID_Ctrl_In = 9'h155;
    step();
    check_ifid("fetch0c", 32'h10, 32'h3333_000C, 32'h10, 1'b1);
    check("fetch0c_ctrl", {23'b0, ID_EX_Ctrl}, 32'h155);

    // One-cycle load-use stall at PC = 0x10
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    Instr_In = 32'h3333_0010;
    step();
    check_ifid("stall", 32'h10, 32'h3333_000C, 32'h10, 1'b1);
    check("stall_ctrl", {23'b0, ID_EX_Ctrl}, 32'h0);
    check("stall_cnt", {28'b0, Stall_Count}, 32'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    ID_Ctrl_In = 9'h0AA;
    step();
    check_ifid("resume", 32'h14, 32'h3333_0010, 32'h14, 1'b1);
    check("resume_ctrl", {23'b0, ID_EX_Ctrl}, 32'h0AA);
    check("resume_stall", {28'b0, Stall_Count}, 32'd1);

    // Flush wins over a simultaneous stall
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    step();
    check_ifid("flush", 32'h200, 32'h0, 32'h0, 1'b0);
    check("flush_ctrl", {23'b0, ID_EX_Ctrl}, 32'h0);
    check("flush_cnt", {28'b0, Flush_Count}, 32'd2);
    check("flush_stall", {28'b0, Stall_Count}, 32'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    Instr_In = 32'h4444_0200; ID_Ctrl_In = 9'h101;
    step();
    check_ifid("target", 32'h204, 32'h4444_0200, 32'h204, 1'b1);
    check("target_ctrl", {23'b0, ID_EX_Ctrl}, 32'h101);

    // PC wrap at the top of the address space
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    check_ifid("brtop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    Instr_In = 32'h5555_FFFC;
    step();
    check_ifid("wrap", 32'h0, 32'h5555_FFFC, 32'h0, 1'b1);

    // PC advances while IF/ID holds
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    Instr_In = 32'h6666_0000;
    step();
    check_ifid("skip", 32'h4, 32'h5555_FFFC, 32'h0, 1'b1);

    // Held bubble saturates the 4-bit stall counter
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("sat%0d", i), {28'b0, Stall_Count}, (1 + i > 15) ? 32'd15 : 32'(1 + i));
    end
    check_ifid("sathold", 32'h4, 32'h5555_FFFC, 32'h0, 1'b1);

    // Asynchronous reset between edges during a stall
    #2 Rst = 1'b1;
    #1;
    check_ifid("arst", 32'h40, 32'h0, 32'h0, 1'b0);
    check("arst_ctrl", {23'b0, ID_EX_Ctrl}, 32'h0);
    check("arst_stall", {28'b0, Stall_Count}, 32'h0);
    check("arst_flush", {28'b0, Flush_Count}, 32'h0);
    #1 Rst = 1'b0;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    Instr_In = 32'h7777_0040; ID_Ctrl_In = 9'h033;
    step();
    check_ifid("post", 32'h44, 32'h7777_0040, 32'h44, 1'b1);
    check("post_ctrl", {23'b0, ID_EX_Ctrl}, 32'h033);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
